// File: rtl/cas_pkg.sv
// Shared types and timing constants for the cassette FSK player.
package cas_pkg;
    localparam int CW             = 16;
    localparam int CLK_HZ_DEFAULT = 28636360;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    // 1200 Hz and 2400 Hz half-periods in clk_sys cycles, truncated.
    function automatic int half0(input int clk_hz);
        return clk_hz / 2400;
    endfunction

    function automatic int half1(input int clk_hz);
        return clk_hz / 4800;
    endfunction

    localparam int HALF0_DEFAULT = half0(CLK_HZ_DEFAULT);
    localparam int HALF1_DEFAULT = half1(CLK_HZ_DEFAULT);
endpackage

// File: rtl/cas_half_timer.sv
// Half-period counter: restarts on start or done, pulses done on the last cycle of a half-period.
module cas_half_timer
    import cas_pkg::*;
#(
    parameter int HALF0 = HALF0_DEFAULT,
    parameter int HALF1 = HALF1_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    input  logic sel1,
    output logic done
);
    localparam logic [CW-1:0] LAST0 = CW'(HALF0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(HALF1 - 1);

    logic [CW-1:0] hc;
    logic [CW-1:0] last;

    assign last = sel1 ? LAST1 : LAST0;
    assign done = run && (hc == last);

    always_ff @(posedge clk_sys) begin
        if (!reset_n || start || done) begin
            hc <= '0;
        end else if (run) begin
            hc <= hc + 1'b1;
        end
    end
endmodule

// File: rtl/cas_player.sv
// CoCo/MC-10 FSK cassette player: serialises bytes LSB first, one full cycle per bit.
//   state | meaning
//   IDLE  | no byte in flight, cin low, ready while play is high
//   HI    | high half of the current bit
//   LO    | low half of the current bit; last LO cycle of bit 7 may chain the next byte
module cas_player
    import cas_pkg::*;
#(
    parameter int          CLK_HZ  = CLK_HZ_DEFAULT,
    parameter logic [15:0] BC_INIT = 16'd0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        play,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        cin,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] byte_count
);
    localparam int HALF0 = half0(CLK_HZ);
    localparam int HALF1 = half1(CLK_HZ);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  sh;
    logic [2:0]  bi;
    logic        done;
    logic        accept;
    logic        byte_end;

    assign byte_end = (state == LO) && done && (bi == 3'd7);
    assign accept   = s_valid && s_ready;

    cas_half_timer #(
        .HALF0 (HALF0),
        .HALF1 (HALF1)
    ) u_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (accept),
        .run     (state != IDLE),
        .sel1    (sh[0]),
        .done    (done)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = HI;
            HI:      if (done) state_nxt = LO;
            LO:      if (done) state_nxt = ((bi != 3'd7) || accept) ? HI : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted so nothing is offered during reset.
    always_comb begin
        cin     = (state == HI);
        busy    = (state != IDLE);
        s_ready = 1'b0;
        if (reset_n) begin
            if (state == IDLE) begin
                s_ready = play;
            end else if (byte_end) begin
                s_ready = play && s_valid;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sh         <= '0;
            bi         <= '0;
            byte_count <= BC_INIT;
            underrun   <= 1'b0;
        end else begin
            if (accept) begin
                sh <= s_data;
                bi <= 3'd0;
            end else if ((state == LO) && done) begin
                sh <= sh >> 1;
                bi <= bi + 3'd1;
            end
            if (byte_end) begin
                byte_count <= byte_count + 16'd1;
            end
            if (!play) begin
                underrun <= 1'b0;
            end else if (byte_end && !s_valid) begin
                underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player with a queue-of-levels waveform model and literal checks.
module tb_cas_player;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        play;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        cin;
    logic        busy;
    logic        underrun;
    logic [15:0] byte_count;

    logic        reset2_n;
    logic        play2;
    logic        ready2;
    logic        cin2;
    logic        busy2;
    logic        und2;
    logic [15:0] count2;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    cas_player #(.CLK_HZ(48000)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .play       (play),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .cin        (cin),
        .busy       (busy),
        .underrun   (underrun),
        .byte_count (byte_count)
    );

    // Fast instance whose counter starts two bytes short of wrapping.
    cas_player #(.CLK_HZ(4800), .BC_INIT(16'hFFFE)) dut_wrap (
        .clk_sys    (clk_sys),
        .reset_n    (reset2_n),
        .play       (play2),
        .s_data     (8'hFF),
        .s_valid    (1'b1),
        .s_ready    (ready2),
        .cin        (cin2),
        .busy       (busy2),
        .underrun   (und2),
        .byte_count (count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the pending waveform is a queue of cin levels, one entry per clock cycle.
    bit          q[$];
    logic [15:0] m_count;
    bit          m_und;
    bit          m_live = 1'b0;

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            int h;
            h = b[i] ? 10 : 20;
            for (int k = 0; k < h; k++) q.push_back(1'b1);
            for (int k = 0; k < h; k++) q.push_back(1'b0);
        end
    endfunction

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            q.delete();
            m_count = 16'd0;
            m_und   = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            bit idle;
            bit last;
            idle = (q.size() == 0);
            last = (q.size() == 1);
            if (!idle) void'(q.pop_front());
            if (last) begin
                m_count = m_count + 16'd1;
                if (play && !s_valid) m_und = 1'b1;
            end
            if ((idle || last) && play && s_valid) push_byte(s_data);
            if (!play) m_und = 1'b0;
        end
    end

    always @(negedge clk_sys) begin
        if (m_live) begin
            bit e_cin;
            bit e_rdy;
            e_cin = (q.size() > 0) ? q[0] : 1'b0;
            e_rdy = reset_n && (((q.size() == 0) && play) || ((q.size() == 1) && play && s_valid));
            check("cin", cin, e_cin);
            check("busy", busy, q.size() > 0);
            check("s_ready", s_ready, e_rdy);
            check("byte_count", byte_count, m_count);
            check("underrun", underrun, m_und);
        end
    end

    int mon_busy = 0;
    int mon_hi   = 0;
    int mon_rdy  = 0;

    always @(negedge clk_sys) begin
        if (busy === 1'b1) mon_busy++;
        if (busy === 1'b1 && cin === 1'b1) mon_hi++;
        if (busy === 1'b1 && s_ready === 1'b1) mon_rdy++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (busy === 1'b0) return;
        end
        total++;
        bad++;
        $display("FAIL %s: busy still high after 3000 cycles", name);
    endtask

    int b0, h0, r0;
    logic [15:0] seen[$];
    logic [15:0] prev;

    initial begin
        reset_n  = 1'b0;
        play     = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        reset2_n = 1'b0;
        play2    = 1'b0;

        // Single 0x01 byte
        do_reset();
        check("rst_byte_count", byte_count, 16'd0);
        check("rst_ready_play0", s_ready, 1'b0);
        play = 1'b1;
        step(1);
        b0 = mon_busy; h0 = mon_hi;
        s_data = 8'h01; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        wait_idle("b01_idle");
        check("b01_busy_cycles", mon_busy - b0, 300);
        check("b01_high_cycles", mon_hi - h0, 150);
        check("b01_count", byte_count, 16'd1);
        check("b01_underrun", underrun, 1'b1);
        play = 1'b0;
        step(1);
        check("b01_underrun_clr", underrun, 1'b0);

        // Back-to-back 0xFF then 0x00
        do_reset();
        play = 1'b1;
        step(1);
        b0 = mon_busy; h0 = mon_hi; r0 = mon_rdy;
        s_data = 8'hFF; s_valid = 1'b1;
        step(1);
        s_data = 8'h00;
        step(160);
        s_valid = 1'b0;
        wait_idle("b2b_idle");
        check("b2b_busy_cycles", mon_busy - b0, 480);
        check("b2b_high_cycles", mon_hi - h0, 240);
        check("b2b_ready_pulses", mon_rdy - r0, 1);
        check("b2b_count", byte_count, 16'd2);

        // 0xA5 followed by an empty stream
        do_reset();
        play = 1'b1;
        step(1);
        b0 = mon_busy;
        s_data = 8'hA5; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        wait_idle("a5_idle");
        check("a5_busy_cycles", mon_busy - b0, 240);
        check("a5_underrun", underrun, 1'b1);
        check("a5_cin_idle", cin, 1'b0);
        play = 1'b0;
        step(1);
        check("a5_underrun_clr", underrun, 1'b0);

        // Drop play inside bit 3 of 0x3C, s_valid kept high
        do_reset();
        play = 1'b1;
        step(1);
        b0 = mon_busy;
        s_data = 8'h3C; s_valid = 1'b1;
        step(1);
        step(105);
        play = 1'b0;
        wait_idle("3c_idle");
        check("3c_busy_cycles", mon_busy - b0, 240);
        step(30);
        check("3c_no_accept", busy, 1'b0);
        check("3c_count", byte_count, 16'd1);
        s_valid = 1'b0;

        // Reset in the middle of a byte, then a clean byte
        do_reset();
        play = 1'b1;
        step(1);
        s_data = 8'h00; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        step(50);
        reset_n = 1'b0;
        step(1);
        check("midrst_cin", cin, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_count", byte_count, 16'd0);
        reset_n = 1'b1;
        step(1);
        b0 = mon_busy; h0 = mon_hi;
        s_data = 8'h01; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        wait_idle("postrst_idle");
        check("postrst_busy_cycles", mon_busy - b0, 300);
        check("postrst_high_cycles", mon_hi - h0, 150);
        check("postrst_count", byte_count, 16'd1);
        play = 1'b0;
        step(1);

        // Counter wrap on the fast instance
        reset2_n = 1'b0;
        step(2);
        check("wrap_rst_count", count2, 16'hFFFE);
        reset2_n = 1'b1;
        play2 = 1'b1;
        prev = count2;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (count2 !== prev) begin
                seen.push_back(count2);
                prev = count2;
            end
        end
        play2 = 1'b0;
        step(40);
        check("wrap_events", seen.size() >= 3, 1'b1);
        if (seen.size() >= 3) begin
            check("wrap_ffff", seen[0], 16'hFFFF);
            check("wrap_0000", seen[1], 16'h0000);
            check("wrap_0001", seen[2], 16'h0001);
        end
        check("wrap_idle", busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cas_player.md
Name: cas_player

Overview:
Cassette waveform generator that drives the MC-10 `cin` input, the playback counterpart to the CPU's bit-banged cassette output.
- Takes a byte stream (e.g. from an SD/OSD tape image loader) and serialises it in CoCo/MC-10 FSK format:
  - bit 1 = one cycle at 2400 Hz;
  - bit 0 = one cycle at 1200 Hz;
  - LSB first, no start or stop bits.
- Sits beside the mc10 core in `clk_sys`; its `cin` output feeds the core's `cin` input.

Parameters:
- CLK_HZ, 28636360, frequency of clk_sys in Hz.
- HALF0, CLK_HZ/2400, clk_sys cycles per half-period of a 0 bit (1200 Hz). Integer division truncates.
- HALF1, CLK_HZ/4800, clk_sys cycles per half-period of a 1 bit (2400 Hz). Integer division truncates.
- CW, 16, width of the half-period counter. Must satisfy HALF0 < 2^CW.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- play  in  1  level; 1 = playback enabled.
- s_data  in  8  byte to play.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block accepts s_data this cycle.
- cin  out  1  cassette signal level to the core.
- busy  out  1  a byte is being serialised.
- underrun  out  1  sticky flag: play was high, the stream was empty at a byte boundary, and a byte had been sent earlier.
- byte_count  out  16  bytes fully played; wraps from 0xFFFF to 0.

Behaviour:
- Reset (reset_n=0 on a clock edge): all outputs take their reset values on that edge.
  - cin=0, busy=0, s_ready=0, underrun=0, byte_count=0.
  - State goes to IDLE.
  - Reset during a byte aborts it immediately; byte_count is not incremented.
- States: IDLE, HI, LO.
  - Registers: shift register sh[7:0], bit index bi[2:0], half counter hc[CW-1:0].
- IDLE:
  - cin=0, busy=0.
  - s_ready = play (combinational).
  - On s_valid & s_ready: sh <= s_data, bi <= 0, hc <= 0, go to HI.
  - cin=1 from the next cycle, i.e. 1-cycle latency from acceptance.
- Half-period length: H = HALF1 if sh[0] is 1, else HALF0.
- HI:
  - cin=1, busy=1.
  - hc counts up each cycle.
  - When hc == H-1: hc <= 0, go to LO.
- LO:
  - cin=0, busy=1.
  - When hc == H-1 and bi != 7: shift sh right, bi <= bi+1, hc <= 0, go to HI.
  - When hc == H-1 and bi == 7 (byte end): byte_count <= byte_count+1.
    - If play & s_valid: s_ready=1 on this cycle. Load the new byte and go to HI with no gap (back-to-back).
    - Otherwise go to IDLE.
  - s_ready is 0 in HI and LO except on that final cycle.
- Byte duration: 2 × sum of H over the 8 bits, in cycles.
- play deasserted mid-byte: the current byte completes; then IDLE and no new accept.
- underrun:
  - Set on a byte-end cycle where play=1, s_valid=0 and byte_count (before increment) was nonzero or the byte just completed.
  - Cleared when play=0.
  - Simultaneous set and clear: clear wins.
- s_data is sampled only on the accept cycle; later changes are ignored.
- s_valid while play=0: not accepted, no state change.

Decomposition:
- Shared package cas_pkg:
  - state enum {IDLE, HI, LO};
  - localparams for the HALF0/HALF1 derivation from CLK_HZ;
  - CW.
- One sub-module, cas_half_timer: loadable half-period counter. Inputs are a start pulse and a length select; output is a `done` pulse on the last cycle of a half-period.
- The FSM and shift register stay in cas_player.

Test Plan:
- CLK_HZ=48000 (HALF0=20, HALF1=10), play=1, send 0x01 → cin sequence:
  - 10 high, 10 low;
  - then 7 × (20 high, 20 low);
  - 300 cycles total, busy=1 throughout, then byte_count=1.
- Back-to-back 0xFF then 0x00, s_valid held:
  - 0xFF = 8 × (10 high, 10 low) = 160 cycles;
  - 0x00 follows with no idle cycle, 320 cycles;
  - s_ready pulses exactly once at the byte-0 end; byte_count=2.
- Send 0xA5, then hold s_valid=0 with play=1 → after the byte, IDLE, cin=0, underrun=1. Drop play → underrun=0.
- Drop play mid-bit 3 of 0x3C → byte finishes at its full 2×(4×10+4×20)=240 cycles; no further accept even with s_valid=1.
- Assert reset_n=0 mid-byte → next cycle cin=0, busy=0, byte_count=0. After release, a new byte plays from bit 0.
- Send 256 bytes with byte_count preset near wrap (start from 0xFFFE via 65534 bytes at minimal HALF) → the counter wraps 0xFFFF→0x0000.
